bpsk_bit_sync: RTL
==================

Name: bpsk_bit_sync

Overview:
- Symbol-timing recovery and bit slicer placed directly downstream of the Costas loop.
- Consumes the signed baseband demodulator output at the 100 MHz sample rate.
- Recovers symbol boundaries with a zero-crossing DPLL, integrate-and-dumps each symbol, and emits one hard bit per symbol with a valid strobe and a lock flag.

Parameters:
- DW, 12, input sample width (matches the Costas demod output).
- SPS_NOM, 100, nominal samples per symbol.
- CNT_W, 8, symbol counter width; must satisfy 2^CNT_W > SPS_NOM+ADJ_STEP.
- ADJ_STEP, 1, period correction in samples per symbol.
- HYST, 64, zero-crossing hysteresis threshold (absolute sample value).
- LOCK_TOL, 2, maximum |timing error| counted as good.
- LOCK_CNT, 4, consecutive good/bad transitions needed to lock/unlock.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  sample enable; all state holds when low.
- demod_in  in  DW  signed baseband sample.
- bit_out  out  1  sliced bit; 1 when symbol integral >= 0.
- bit_valid  out  1  one-cycle strobe qualifying bit_out.
- locked  out  1  high in LOCKED state.
- timing_err  out  CNT_W  signed error of the last detected transition, held between transitions.

Behaviour:
- Reset (rst=0 at clk edge): bit_out=0, bit_valid=0, locked=0, timing_err=0. Also clears cnt, acc, good/bad counters and hysteresis sign (positive); period=SPS_NOM; state=SEARCH.
- en=0: nothing updates; bit_valid=0 that cycle.
- Zero-crossing detector: sign state flips only when demod_in > +HYST (to positive) or < -HYST (to negative). The flip cycle raises zc.
- Symbol counter cnt runs 0..period-1 on en cycles, then wraps to 0.
- Accumulator acc has width DW+CNT_W, signed. It adds demod_in each en cycle and reloads with demod_in at cnt==0.
- Dump: on the en cycle with cnt==period-1, final = acc+demod_in. Next cycle, bit_out=(final>=0) and bit_valid=1. Latency is 1 cycle after the last sample.
- Timing error on zc at count c: e = c if c < SPS_NOM/2, else c-SPS_NOM. Stored to timing_err and held as the pending error; the last zc in a symbol wins.
- Period update at wrap: pending e>0 gives period=SPS_NOM+ADJ_STEP; e<0 gives SPS_NOM-ADJ_STEP; no zc or e==0 gives SPS_NOM. Pending error clears at wrap.
- A zc coincident with the wrap cycle belongs to the ending symbol.
- FSM:
  - SEARCH: no bits emitted. First zc forces cnt=0 and acc=demod_in on that sample (hard align), clears counters, goes to TRACK.
  - TRACK: bits emitted. A zc with |e|<=LOCK_TOL increments good; |e|>LOCK_TOL clears good. good==LOCK_CNT goes to LOCKED.
  - LOCKED: bits emitted. |e|>LOCK_TOL increments bad; a good zc clears bad. bad==LOCK_CNT goes to SEARCH.
- The first symbol after hard align is emitted normally at its wrap. Partial symbols before align are discarded.

Optional Feature:
- BIT_SYNC_DIFF_DECODE_EN defined: bit_out = slice XOR previous slice, which removes the Costas 180-degree ambiguity. The previous slice is cleared to 0 on reset and on entry to SEARCH.
- Undefined: bit_out = raw slice.
- Strobe timing is identical in both cases.

Decomposition:
- Package bit_sync_pkg: FSM state enum (SEARCH, TRACK, LOCKED), accumulator width constant, signed-error type.
- One sub-module, bit_sync_zc_det: hysteresis sign register and zc pulse.

Test Plan:
- Reset: hold rst=0 for 5 cycles with random input -> all outputs 0, state SEARCH, no bit_valid.
- Aligned ±1000 alternating symbols, 100 samples each -> hard align on first edge; bits 1,0,1,0 with bit_valid every 100 cycles; locked after the 4th good transition; timing_err=0.
- Symbols of 101 samples for 200 symbols -> periods alternate 100/101; locked stays 1; no bit slip; |timing_err|<=1.
- Input ±50 random (inside HYST) after lock -> no zc, period stays 100, bits still strobed every 100 cycles.
- en=0 for 37 cycles mid-symbol -> next bit_valid delayed exactly 37 cycles, bit sequence unchanged.
- Constant +1000 after lock -> bits all 1 without the macro, all 0 with BIT_SYNC_DIFF_DECODE_EN. Then 4 edges with e=+30 -> locked drops and FSM returns to SEARCH.

Source files
------------

// File: rtl/bit_sync_pkg.sv
// bit_sync_pkg: shared types and default widths for the BPSK bit synchroniser.
package bit_sync_pkg;

    localparam int unsigned DW_DEF    = 12;
    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned ACC_W_DEF = DW_DEF + CNT_W_DEF;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef logic signed [CNT_W_DEF-1:0] err_t;

endpackage

// File: rtl/bit_sync_zc_det.sv
// bit_sync_zc_det: hysteresis sign tracker; zc_c pulses on the sample that flips the sign.
module bit_sync_zc_det
    import bit_sync_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned HYST = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [DW-1:0] sample,
    output logic                 zc_c
);

    localparam logic signed [DW-1:0] HYST_POS = DW'(HYST);
    localparam logic signed [DW-1:0] HYST_NEG = -HYST_POS;

    logic pos;

    always_comb begin
        zc_c = en && (pos ? (sample < HYST_NEG) : (sample > HYST_POS));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pos <= 1'b1;
        end else if (zc_c) begin
            pos <= ~pos;
        end
    end

endmodule

// File: rtl/bpsk_bit_sync.sv
// bpsk_bit_sync: zero-crossing DPLL symbol timing, integrate-and-dump slicer and lock detector.
// Build option BIT_SYNC_DIFF_DECODE_EN: differentially decode the sliced bits.
module bpsk_bit_sync
    import bit_sync_pkg::*;
#(
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned SPS_NOM  = 100,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned ADJ_STEP = 1,
    parameter int unsigned HYST     = 64,
    parameter int unsigned LOCK_TOL = 2,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [DW-1:0]    demod_in,
    output logic                    bit_out,
    output logic                    bit_valid,
    output logic                    locked,
    output logic signed [CNT_W-1:0] timing_err
);

    localparam int unsigned ACC_W = DW + CNT_W;
    localparam int unsigned GW    = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]        SPS    = CNT_W'(SPS_NOM);
    localparam logic [CNT_W-1:0]        PER_HI = CNT_W'(SPS_NOM + ADJ_STEP);
    localparam logic [CNT_W-1:0]        PER_LO = CNT_W'(SPS_NOM - ADJ_STEP);
    localparam logic [CNT_W-1:0]        HALF   = CNT_W'(SPS_NOM / 2);
    localparam logic signed [CNT_W-1:0] TOL    = CNT_W'(LOCK_TOL);
    localparam logic [GW-1:0]           LCNT   = GW'(LOCK_CNT);

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          cnt, period;
    logic signed [ACC_W-1:0]   acc;
    logic signed [CNT_W-1:0]   pend;
    logic [GW-1:0]             good, bad;

    logic                      zc_c, align_c, emit_c, wrap_c, good_zc_c, slice_c, bit_d_c;
    logic signed [CNT_W-1:0]   err_c, err_sel_c;
    logic signed [ACC_W-1:0]   ext_c, final_c;

    bit_sync_zc_det #(
        .DW   (DW),
        .HYST (HYST)
    ) u_zc (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .sample (demod_in),
        .zc_c   (zc_c)
    );

    // Timing error folds the count around the nominal mid-symbol point.
    always_comb begin
        wrap_c    = en && (cnt == period - CNT_W'(1));
        err_c     = (cnt < HALF) ? $signed(cnt) : $signed(cnt - SPS);
        good_zc_c = (err_c <= TOL) && (err_c >= -TOL);
        err_sel_c = zc_c ? err_c : pend;
        ext_c     = {{CNT_W{demod_in[DW-1]}}, demod_in};
        final_c   = acc + ext_c;
        slice_c   = ~final_c[ACC_W-1];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH:  if (zc_c) state_nxt = TRACK;
            TRACK:   if (zc_c && good_zc_c && (good + GW'(1)) == LCNT) state_nxt = LOCKED;
            LOCKED:  if (zc_c && !good_zc_c && (bad + GW'(1)) == LCNT) state_nxt = SEARCH;
            default: state_nxt = SEARCH;
        endcase
    end

    always_comb begin
        align_c = 1'b0;
        emit_c  = 1'b0;
        case (state)
            SEARCH:        align_c = zc_c;
            TRACK, LOCKED: emit_c  = wrap_c;
            default:       ;
        endcase
    end

`ifdef BIT_SYNC_DIFF_DECODE_EN
    logic prev_slice;

    always_comb bit_d_c = slice_c ^ prev_slice;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_slice <= 1'b0;
        end else if (en) begin
            if (state != SEARCH && state_nxt == SEARCH) begin
                prev_slice <= 1'b0;
            end else if (emit_c) begin
                prev_slice <= slice_c;
            end
        end
    end
`else
    always_comb bit_d_c = slice_c;
`endif

    // Hard align treats the first crossing as sample 0 of a fresh symbol.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            period     <= SPS;
            acc        <= '0;
            pend       <= '0;
            good       <= '0;
            bad        <= '0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            locked     <= 1'b0;
            timing_err <= '0;
        end else begin
            bit_valid <= 1'b0;
            if (en) begin
                bit_valid <= emit_c;
                locked    <= (state_nxt == LOCKED);
                if (emit_c) begin
                    bit_out <= bit_d_c;
                end
                if (align_c) begin
                    cnt        <= CNT_W'(1);
                    acc        <= ext_c;
                    pend       <= '0;
                    period     <= SPS;
                    timing_err <= '0;
                    good       <= '0;
                    bad        <= '0;
                end else begin
                    cnt <= wrap_c ? '0 : cnt + CNT_W'(1);
                    acc <= (cnt == '0) ? ext_c : final_c;
                    if (zc_c) begin
                        timing_err <= err_c;
                        pend       <= err_c;
                        if (state == TRACK) begin
                            good <= good_zc_c ? good + GW'(1) : '0;
                            bad  <= '0;
                        end
                        if (state == LOCKED) begin
                            bad <= good_zc_c ? '0 : bad + GW'(1);
                        end
                    end
                    if (wrap_c) begin
                        pend <= '0;
                        if (!err_sel_c[CNT_W-1] && err_sel_c != '0) begin
                            period <= PER_HI;
                        end else if (err_sel_c[CNT_W-1]) begin
                            period <= PER_LO;
                        end else begin
                            period <= SPS;
                        end
                    end
                end
            end
        end
    end

endmodule
